trng_fifo_read_arbiter: RTL

//  Round-robin read scheduler for the 8-bit TRNG entropy FIFO. Shares the FIFO

---
 rtl/trng_fifo_read_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/trng_fifo_read_arbiter.sv
// trng_fifo_read_arbiter
//   Round-robin read scheduler for the 8-bit TRNG entropy FIFO. A granted
//   consumer receives BYTES freshly popped bytes packed little-endian into one
//   word, delivered over a valid/ready handshake.
// Ports
//   clk, reset_n        clock (rising edge), synchronous active-low reset
//   fifo_empty          FIFO empty flag
//   fifo_data [7:0]     FIFO read data, valid the cycle after a pop
//   fifo_rd_en          FIFO pop strobe
//   req   [NREQ-1:0]    per-requester word request (level)
//   grant [NREQ-1:0]    one-hot owner, 0 when idle
//   word_valid [NREQ-1:0] one-hot word-available flag (within grant)
//   word_ready [NREQ-1:0] per-requester accept
//   word_data [8*BYTES-1:0] packed word, first popped byte in [7:0]
//   busy                high whenever not idle
//   starved             sticky until next grant: fetch stalled >= STALL_LIMIT
module trng_fifo_read_arbiter #(
  parameter int NREQ        = 2,
  parameter int BYTES       = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_data,
  output logic                 fifo_rd_en,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      word_valid,
  input  logic [NREQ-1:0]      word_ready,
  output logic [8*BYTES-1:0]   word_data,
  output logic                 busy,
  output logic                 starved
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BYTES + 1);
  localparam int SW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam int WW = 8 * BYTES;
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DELIVER
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   captured_q, captured_d;
  logic            cap_q, cap_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            starved_q, starved_d;
  logic            valid_q, valid_d;
  logic [WW-1:0]   word_q, word_d;

  logic            found;
  logic            can_pop;
  logic            handshake;
  int unsigned     idx;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    issued_d   = issued_q;
    captured_d = captured_q;
    cap_d      = 1'b0;
    stall_d    = stall_q;
    starved_d  = starved_q;
    valid_d    = valid_q;
    word_d     = word_q;
    fifo_rd_en = 1'b0;
    found      = 1'b0;
    idx        = 0;
    can_pop    = issued_q < CW'(BYTES);
    handshake  = (state_q == S_DELIVER) && |(word_ready & grant_q);

    case (state_q)
      S_IDLE: begin
        // Circular scan starting at the round-robin pointer.
        for (int unsigned i = 0; i < NREQ_U; i++) begin
          idx = (32'(rr_q) + i) % NREQ_U;
          if (!found && req[idx]) begin
            found          = 1'b1;
            grant_d        = '0;
            grant_d[idx]   = 1'b1;
            gidx_d         = PW'(idx);
          end
        end
        if (found) begin
          state_d    = S_FETCH;
          issued_d   = '0;
          captured_d = '0;
          stall_d    = '0;
          starved_d  = 1'b0;
        end
      end

      S_FETCH: begin
        fifo_rd_en = can_pop && !fifo_empty;
        cap_d      = fifo_rd_en;
        if (fifo_rd_en) begin
          issued_d = issued_q + CW'(1);
        end
        // Byte popped last cycle is on fifo_data now.
        if (cap_q) begin
          for (int unsigned b = 0; b < BYTES; b++) begin
            if (captured_q == CW'(b)) begin
              word_d[8*b +: 8] = fifo_data;
            end
          end
          captured_d = captured_q + CW'(1);
        end
        if (can_pop && fifo_empty && (stall_q < SW'(STALL_LIMIT))) begin
          stall_d = stall_q + SW'(1);
        end
        if (stall_d >= SW'(STALL_LIMIT)) begin
          starved_d = 1'b1;
        end
        if (captured_q == CW'(BYTES)) begin
          state_d = S_DELIVER;
          valid_d = 1'b1;
        end
      end

      S_DELIVER: begin
        if (handshake) begin
          grant_d = '0;
          valid_d = 1'b0;
          state_d = S_IDLE;
          rr_d    = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_q       <= '0;
      issued_q   <= '0;
      captured_q <= '0;
      cap_q      <= 1'b0;
      stall_q    <= '0;
      starved_q  <= 1'b0;
      valid_q    <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      cap_q      <= cap_d;
      stall_q    <= stall_d;
      starved_q  <= starved_d;
      valid_q    <= valid_d;
      word_q     <= word_d;
    end
  end

  assign grant      = grant_q;
  assign word_valid = valid_q ? grant_q : '0;
  assign word_data  = word_q;
  assign busy       = (state_q != S_IDLE);
  assign starved    = starved_q;

endmodule
